// File: rtl/decoder_n_scan_if.sv
// rtl/decoder_n_scan_if.sv - control and decode bundle for decoder_n_scan
//
// Purpose: groups the enable/mode/select inputs and the registered decode
// outputs of decoder_n_scan into one interface.
// Signals:
//   G     enable; 0 forces OUT inactive and freezes the scan position
//   MODE  0 = DIRECT (decode SEL), 1 = SCAN (self-stepping index)
//   SEL   decode index, N bits, used in DIRECT mode only
//   OUT   registered one-hot decode, 2**N bits
//   IDX   registered index currently shown on OUT, N bits
//   WRAP  one-cycle pulse when the scan index wraps to 0
// Modports: master drives G/MODE/SEL, slave (the decoder) drives OUT/IDX/WRAP.
interface decoder_n_scan_if #(
  parameter int N = 3
);
  logic             G;
  logic             MODE;
  logic [N-1:0]     SEL;
  logic [2**N-1:0]  OUT;
  logic [N-1:0]     IDX;
  logic             WRAP;

  modport master (
    output G, MODE, SEL,
    input  OUT, IDX, WRAP
  );

  modport slave (
    input  G, MODE, SEL,
    output OUT, IDX, WRAP
  );
endinterface

// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - registered N-to-2**N decoder with direct and scan modes
//
// Purpose: one-hot decoder whose index comes either from SEL (DIRECT) or from
// an internal counter that advances every PRESCALE enabled cycles (SCAN), for
// multiplexing display digits or LED matrix rows. All outputs are registered.
// Ports:
//   CLK    system clock, all state updates on the rising edge
//   RESET  synchronous, active-high reset
//   bus    decoder_n_scan_if slave modport (G, MODE, SEL in; OUT, IDX, WRAP out)
module decoder_n_scan #(
  parameter int N          = 3,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           CLK,
  input  logic           RESET,
  decoder_n_scan_if.slave bus
);
  localparam int W  = 2**N;
  // A prescale of 1 still needs a 1-bit counter so the compare logic is uniform.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  IDX_LAST  = {N{1'b1}};
  localparam logic [W-1:0]  INACTIVE  = {W{ACTIVE_LOW}};

  logic [N-1:0]  idx_q, idx_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          wrap_q, wrap_d;
  logic [W-1:0]  out_q, out_d;

  // Polarity is applied here so OUT never needs a second inversion stage.
  function automatic logic [W-1:0] decode(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v ^ INACTIVE;
  endfunction

  always_comb begin
    idx_d  = idx_q;
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    out_d  = INACTIVE;
    if (!bus.MODE) begin
      // DIRECT: index tracks SEL even while disabled, so a later switch to
      // SCAN starts from the last selected position with a fresh prescaler.
      idx_d  = bus.SEL;
      pcnt_d = '0;
      if (bus.G) begin
        out_d = decode(bus.SEL);
      end
    end else if (bus.G) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        idx_d  = idx_q + N'(1);
        out_d  = decode(idx_q + N'(1));
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        pcnt_d = pcnt_q + PW'(1);
        out_d  = decode(idx_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q  <= '0;
      pcnt_q <= '0;
      wrap_q <= 1'b0;
      out_q  <= INACTIVE;
    end else begin
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
      out_q  <= out_d;
    end
  end

  assign bus.OUT  = out_q;
  assign bus.IDX  = idx_q;
  assign bus.WRAP = wrap_q;
endmodule
